// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, reads the instruction ROM and queues
// {pc, instr} pairs for decode over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   imem_addr_o        byte address to the combinational ROM (= fetch_pc)
//   imem_instr_i       ROM word for imem_addr_o
//   redirect_i         flush the queue and restart fetch at redirect_pc_i
//   redirect_pc_i      redirect target, bits [1:0] ignored
//   instr_valid_o      queue head is valid
//   instr_ready_i      decode accepts the head this cycle
//   instr_o, pc_o      queue head instruction and its PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          queue_q [QUEUE_DEPTH];
    logic [31:0]     fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (count != '0);
    assign instr_o       = queue_q[rd_ptr].instr;
    assign pc_o          = queue_q[rd_ptr].pc;

    // A redirect kills the head even if decode is ready, so it never pops.
    assign pop  = instr_valid_o & instr_ready_i & ~redirect_i;
    // A full queue can still accept a word when the head leaves this cycle.
    assign push = ~redirect_i & ((count < FULL) | pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // Cleared so the head reads zero while empty after reset.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr   <= wr_ptr;
            count    <= '0;
        end else begin
            if (push) begin
                queue_q[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr_i};
                wr_ptr          <= wr_ptr + PW'(1);
                fetch_pc        <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected PCs are queued per scenario
// and compared against every instruction decode accepts.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_addr_o  (imem_addr),
        .imem_instr_i (imem_instr),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .instr_o      (instr),
        .pc_o         (pc)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00 ^ {a[7:0], 24'h0};
    endfunction

    assign imem_instr = rom(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // Advance one cycle; at the negedge, score any accepted head.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (instr_valid === 1'b1 && instr_ready === 1'b1 &&
            redirect === 1'b0 && rst === 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc %h, required none", pc);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e || instr !== rom(e)) begin
                    n_bad++;
                    $display("FAIL sb_head: got pc %h instr %h, required pc %h instr %h",
                             pc, instr, e, rom(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        instr_ready = 1'b0;
        redirect    = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        do_reset();
        instr_ready = 1'b1;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got valid %b addr %h, required 0 00000000",
                     instr_valid, imem_addr);
        end
        n_cmp++;
        if (pc !== 32'h0 || instr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_head: got pc %h instr %h, required 0 0", pc, instr);
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        wait_drain(c);
        instr_ready = 1'b0;
        n_cmp++;
        if (c !== 5) begin
            n_bad++;
            $display("FAIL reset_stream_cycles: got %0d, required 5", c);
        end
    endtask

    task automatic test_back_pressure();
        int c;
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== rom(32'h0)) begin
                n_bad++;
                $display("FAIL bp_head_stable: got valid %b pc %h instr %h, required 1 0 %h",
                         instr_valid, pc, instr, rom(32'h0));
            end
        end
        n_cmp++;
        if (imem_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL bp_addr_frozen: got %h, required 00000008", imem_addr);
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        instr_ready = 1'b1;
        wait_drain(c);
        instr_ready = 1'b0;
        n_cmp++;
        if (c !== 4) begin
            n_bad++;
            $display("FAIL bp_release_cycles: got %0d, required 4", c);
        end
    endtask

    task automatic test_redirect();
        int c;
        do_reset();
        tick();
        tick();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h13;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h10) begin
            n_bad++;
            $display("FAIL redirect_flush: got valid %b addr %h, required 0 00000010",
                     instr_valid, imem_addr);
        end
        exp_q = '{32'h10, 32'h14};
        wait_drain(c);
        instr_ready = 1'b0;
        n_cmp++;
        if (c !== 3) begin
            n_bad++;
            $display("FAIL redirect_cycles: got %0d, required 3", c);
        end
    endtask

    task automatic test_reset_vs_redirect();
        int c;
        do_reset();
        tick();
        tick();
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        tick();
        rst      = 1'b0;
        redirect = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_wins: got valid %b addr %h pc %h, required 0 0 0",
                     instr_valid, imem_addr, pc);
        end
        exp_q = '{32'h0, 32'h4};
        wait_drain(c);
        instr_ready = 1'b0;
        n_cmp++;
        if (c !== 3) begin
            n_bad++;
            $display("FAIL reset_wins_cycles: got %0d, required 3", c);
        end
    endtask

    task automatic test_reset_midstream();
        int c;
        do_reset();
        instr_ready = 1'b1;
        exp_q = '{32'h0, 32'h4};
        wait_drain(c);
        n_cmp++;
        if (pc !== 32'h8 || instr_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_head: got valid %b pc %h, required 1 00000008",
                     instr_valid, pc);
        end
        do_reset();
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got valid %b addr %h, required 0 0",
                     instr_valid, imem_addr);
        end
        instr_ready = 1'b1;
        exp_q = '{32'h0, 32'h4};
        wait_drain(c);
        instr_ready = 1'b0;
        n_cmp++;
        if (c !== 3) begin
            n_bad++;
            $display("FAIL mid_latency: got %0d, required 3", c);
        end
    endtask

    task automatic test_wrap();
        int c;
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_redirect: got addr %h valid %b, required fffffffc 0",
                     imem_addr, instr_valid);
        end
        exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        instr_ready = 1'b1;
        wait_drain(c);
        instr_ready = 1'b0;
        n_cmp++;
        if (c !== 4) begin
            n_bad++;
            $display("FAIL wrap_cycles: got %0d, required 4", c);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        test_reset();
        test_back_pressure();
        test_redirect();
        test_reset_vs_redirect();
        test_reset_midstream();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
